// File: rtl/sum_3_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sum_3_pkg
//  Description : Shared widths, typedefs and state encoding for the 3-sample
//                moving-sum stage and its inverse (sum_3_inv).
//                  SAMPLE_W : width of a signed sample x[n]
//                  SUM_W    : width of the signed running sum s[n]; two extra
//                             bits cover the sum of three full-scale samples
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_3_pkg;

    localparam int SAMPLE_W = 8;
    localparam int SUM_W    = SAMPLE_W + 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    // The inverse filter is either reconstructing (RUN) or halted on an
    // out-of-range reconstruction until cleared (FAULT).
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } inv_state_t;

endpackage : sum_3_pkg
`default_nettype wire

// File: rtl/sample_hist.sv
`default_nettype none
// ============================================================================
//  Module      : sample_hist
//  Description : Three-deep shift register of reconstructed samples. Holds
//                x[n-1], x[n-2], x[n-3] and exposes the oldest tap, which is
//                the x[n-3] term of the inverse recurrence.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous active-low reset (zeroes all taps)
//                clr      - synchronous clear (zeroes all taps, wins over shift)
//                shift_en - push din into the newest tap, age the others
//                din      - sample to push
//                oldest   - oldest tap (sample pushed three shifts ago)
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_hist #(
    parameter int SAMPLE_W = sum_3_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift_en,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] oldest
);

    localparam int DEPTH = 3;

    // r_tap[0] is the newest sample, r_tap[DEPTH-1] the oldest.
    logic [SAMPLE_W-1:0] r_tap [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tap[0] <= '0;
        end else if (clr) begin
            r_tap[0] <= '0;
        end else if (shift_en) begin
            r_tap[0] <= din;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tap
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tap[gi] <= '0;
                end else if (clr) begin
                    r_tap[gi] <= '0;
                end else if (shift_en) begin
                    r_tap[gi] <= r_tap[gi-1];
                end
            end
        end
    endgenerate

    assign oldest = r_tap[DEPTH-1];

endmodule : sample_hist
`default_nettype wire

// File: rtl/sum_3_inv.sv
`default_nettype none
// ============================================================================
//  Module      : sum_3_inv
//  Description : Inverse of the 3-sample moving-sum filter. Rebuilds the
//                signed sample stream from the registered running sum using
//                    x[n] = s[n] - s[n-1] + x[n-3]
//                with all history starting at zero. One sample per clock,
//                one cycle of latency, no backpressure.
//
//  Build option: SUM_3_INV_CHECK_EN
//                  defined   - reconstructions outside the signed sample range
//                              set the sticky err flag and halt the block in
//                              FAULT until clr.
//                  undefined - no range check; the sample wraps to SAMPLE_W
//                              bits, err is tied low and the block always runs.
//
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-low reset
//                clr       - synchronous clear of history and err; a sample
//                            offered in the same cycle is dropped
//                sum       - signed running sum s[n] (SUM_W bits)
//                sum_valid - sum carries a new s[n] this cycle
//                num       - reconstructed signed sample x[n] (SAMPLE_W bits)
//                num_valid - one-cycle pulse per accepted sum
//                err       - sticky reconstruction overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_3_inv #(
    parameter int SAMPLE_W = sum_3_pkg::SAMPLE_W,
    parameter int SUM_W    = sum_3_pkg::SUM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [SUM_W-1:0]    sum,
    input  logic                sum_valid,
    output logic [SAMPLE_W-1:0] num,
    output logic                num_valid,
    output logic                err
);

    import sum_3_pkg::*;

    // Difference path width. s[n] - s[n-1] alone spans SUM_W+1 bits and the
    // x[n-3] term can push an extreme case one bit further, so a second guard
    // bit keeps the range check from ever seeing a wrapped value.
    localparam int D_W = SUM_W + 2;

    logic [SUM_W-1:0]    r_s_prev;
    logic [SAMPLE_W-1:0] w_x_old;
    logic signed [D_W-1:0] w_d;
    logic                w_running;
    logic                w_take;
    logic                w_shift;

    // ------------------------------------------------------------------------
    // Datapath: d = s[n] - s[n-1] + x[n-3], all operands sign-extended.
    // ------------------------------------------------------------------------
    assign w_d = $signed({{(D_W-SUM_W){sum[SUM_W-1]}}, sum})
               - $signed({{(D_W-SUM_W){r_s_prev[SUM_W-1]}}, r_s_prev})
               + $signed({{(D_W-SAMPLE_W){w_x_old[SAMPLE_W-1]}}, w_x_old});

    // A sample is considered only while running; clr always drops it.
    assign w_take = sum_valid && !clr && w_running;

`ifdef SUM_3_INV_CHECK_EN
    inv_state_t r_state;
    inv_state_t w_state_next;
    logic       w_in_range;
    logic       w_overflow;

    // d fits the signed sample iff every bit from the sample sign bit upward
    // is a copy of that sign bit.
    assign w_in_range = (w_d[D_W-1:SAMPLE_W-1] == '0) ||
                        (w_d[D_W-1:SAMPLE_W-1] == '1);

    assign w_shift    = w_take && w_in_range;
    assign w_overflow = w_take && !w_in_range;
    assign w_running  = (r_state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = RUN;
        end else if (w_overflow) begin
            w_state_next = FAULT;
        end
    end

    // err rises on the edge that would have delivered the bad sample and is
    // held until clr; in FAULT no further sample is taken, so it stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (w_overflow) begin
            err <= 1'b1;
        end
    end
`else
    // Without the range check every offered sample is accepted and wraps to
    // SAMPLE_W bits; the guard bits of d carry no information.
    logic w_unused_d;

    assign w_running  = 1'b1;
    assign w_shift    = w_take;
    assign err        = 1'b0;
    assign w_unused_d = ^w_d[D_W-1:SAMPLE_W];
`endif

    // ------------------------------------------------------------------------
    // Output and previous-sum registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num       <= '0;
            num_valid <= 1'b0;
            r_s_prev  <= '0;
        end else begin
            num_valid <= w_shift;
            if (clr) begin
                r_s_prev <= '0;
            end else if (w_shift) begin
                num      <= w_d[SAMPLE_W-1:0];
                r_s_prev <= sum;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sample history: x[n-1], x[n-2], x[n-3]
    // ------------------------------------------------------------------------
    sample_hist #(
        .SAMPLE_W (SAMPLE_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (w_shift),
        .din      (w_d[SAMPLE_W-1:0]),
        .oldest   (w_x_old)
    );

endmodule : sum_3_inv
`default_nettype wire

// File: tb/tb_sum_3_inv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_3_inv
//  Description : Directed self-checking bench for sum_3_inv. Expected samples
//                are queued when a sum is driven and popped when the DUT
//                presents num_valid one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_3_inv;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clr       = 1'b0;
    logic       sum_valid = 1'b0;
    logic [9:0] sum       = '0;
    logic [7:0] num;
    logic       num_valid;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    sum_3_inv dut (
        .clk       (clk),
        .rst       (rst_n),
        .clr       (clr),
        .sum       (sum),
        .sum_valid (sum_valid),
        .num       (num),
        .num_valid (num_valid),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, then check the registered response.
    task automatic cycle(input int s, input bit v, input bit c,
                         input bit exp_v, input int exp_num, input string tag);
        logic [7:0] e;
        sum       = 10'(s);
        sum_valid = v;
        clr       = c;
        if (exp_v) exp_q.push_back(8'(exp_num));
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
        clr       = 1'b0;
        chk({tag, "_valid"}, 16'(num_valid), 16'(exp_v));
        if (exp_q.size() != 0 && (num_valid === 1'b1 || exp_v)) begin
            e = exp_q.pop_front();
            if (num_valid === 1'b1) chk({tag, "_num"}, 16'(num), 16'(e));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_num", 16'(num), 16'h0);
        chk("rst_valid", 16'(num_valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        rst_n = 1'b1;

        // Basic reconstruction: sums 2,3,2 -> 2,1,-1
        cycle(2, 1, 0, 1, 2,  "basic0");
        cycle(3, 1, 0, 1, 1,  "basic1");
        cycle(2, 1, 0, 1, -1, "basic2");
        cycle(0, 0, 0, 0, 0,  "idle");
        chk("hold_num", 16'(num), 16'h00ff);
        chk("basic_err", 16'(err), 16'h0);
        cycle(0, 0, 1, 0, 0, "clr_a");

        // Full-scale boundary: 127,127,127,-128
        cycle(127, 1, 0, 1, 127,  "fs0");
        cycle(254, 1, 0, 1, 127,  "fs1");
        cycle(381, 1, 0, 1, 127,  "fs2");
        cycle(126, 1, 0, 1, -128, "fs3");
        cycle(0, 0, 1, 0, 0, "clr_b");

        // Out-of-range reconstruction: sums 0, 200 (d = 200)
        cycle(0, 1, 0, 1, 0, "ov0");
`ifdef SUM_3_INV_CHECK_EN
        cycle(200, 1, 0, 0, 0, "ov1");
        chk("ov_err", 16'(err), 16'h1);
        cycle(5, 1, 0, 0, 0, "ov_ignored");
        chk("ov_err_sticky", 16'(err), 16'h1);
        cycle(0, 0, 1, 0, 0, "ov_clr");
        chk("ov_err_cleared", 16'(err), 16'h0);
        cycle(5, 1, 0, 1, 5, "ov_recover");
`else
        cycle(200, 1, 0, 1, -56, "wrap");
        chk("wrap_err", 16'(err), 16'h0);
`endif
        cycle(0, 0, 1, 0, 0, "clr_c");

        // clr with same-cycle sample after history 4,4
        cycle(4, 1, 0, 1, 4, "h0");
        cycle(8, 1, 0, 1, 4, "h1");
        cycle(9, 1, 1, 0, 0, "clr_drop");
        cycle(3, 1, 0, 1, 3, "after_clr");
        cycle(0, 0, 1, 0, 0, "clr_d");

        // Asynchronous reset mid-stream
        cycle(2, 1, 0, 1, 2, "ar0");
        cycle(3, 1, 0, 1, 1, "ar1");
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_num", 16'(num), 16'h0);
        chk("arst_valid", 16'(num_valid), 16'h0);
        chk("arst_err", 16'(err), 16'h0);
        #2;
        rst_n = 1'b1;
        cycle(7, 1, 0, 1, 7, "ar_after");

        chk("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sum_3_inv
`default_nettype wire
